dm_ctrl: RTL

- Parametrised successor to the single-cycle data memory.
- Byte-addressed data memory with a valid/ready request port and a configurable wait-state count, which models slower memory.
- Adds load/store alignment and range checking, an error code, and a hardware post-reset clear sweep.
- Sits between the MEM stage and word-wide storage. Word-wide storage with byte enables replaces the byte array.

---
 rtl/dm_pkg.sv | 14 +
 rtl/dm_ram.sv | 20 ++
 rtl/dm_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the data-memory controller
// Memory-op codes, response error codes and controller FSM states.
package dm_pkg;
  typedef enum logic [2:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_e;
  localparam logic [2:0] MOP_W  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_HU = 3'b010;
  localparam logic [2:0] MOP_B  = 3'b011;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_MIS   = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_OP    = 2'b11;
endpackage

// File: rtl/dm_ram.sv
// dm_ram: 2^ADDR_W x 32 single-port storage with byte write enables
// Ports: clk; addr word index; be byte-lane write enables; wdata write word;
// rdata registered read of the addressed word as it was before this cycle's write.
module dm_ram #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[addr];
    for (int i = 0; i < 4; i++) if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: byte-addressed data memory controller with wait states, checks and clear sweep
// Ports: clk; reset (async, active low); req_valid/req_ready handshake with
// req_we, req_memop, req_addr, req_pc, req_wdata; resp_valid one-cycle strobe
// with resp_rdata, resp_err, resp_pc (held between responses); clr_busy during sweep.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned WAIT_CYC  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] resp_pc,
  output logic        clr_busy
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d, idx_q, idx_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic we_q, we_d;
  logic [2:0] op_q, op_d;
  logic [1:0] lo_q, lo_d, err_q, err_d, herr_q, herr_d;
  logic [31:0] pc_q, pc_d, wdata_q, wdata_d, hrdata_q, hrdata_d, hpc_q, hpc_d;
  logic [31:0] off, ram_rdata, wrep, mask, merged, ext, fmt;
  logic [15:0] lane;
  logic [3:0] be;
  logic [1:0] req_err;
  // BASE_ADDR is word aligned, so off[1:0] equals the request's byte offset.
  assign off = req_addr - BASE_ADDR;
  assign req_err = (req_memop > MOP_BU || (req_we && (req_memop == MOP_HU || req_memop == MOP_BU))) ? ERR_OP
                 : |off[31:ADDR_W+2] ? ERR_RANGE
                 : ((req_memop == MOP_W && |off[1:0]) || ((req_memop == MOP_H || req_memop == MOP_HU) && off[0])) ? ERR_MIS
                 : ERR_OK;
  assign be = op_q == MOP_W ? 4'hF : (op_q == MOP_H || op_q == MOP_HU) ? 4'b0011 << {lo_q[1], 1'b0} : 4'b0001 << lo_q;
  assign wrep = op_q == MOP_W ? wdata_q : op_q == MOP_H ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  assign mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  // Storage read data is the pre-write word, so the store response is a merge.
  assign merged = (ram_rdata & ~mask) | (wrep & mask);
  assign lane = 16'(ram_rdata >> {lo_q, 3'b000});
  assign ext = op_q == MOP_B  ? {{24{lane[7]}}, lane[7:0]}
             : op_q == MOP_BU ? {24'h0, lane[7:0]}
             : op_q == MOP_H  ? {{16{lane[15]}}, lane}
             : op_q == MOP_HU ? {16'h0, lane}
             : ram_rdata;
  assign fmt = err_q != ERR_OK ? 32'h0 : we_q ? merged : ext;
  dm_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (state_q == ST_CLEAR ? clr_cnt_q : idx_q),
    .be    (state_q == ST_CLEAR ? 4'hF : (state_q == ST_ACCESS && we_q) ? be : 4'h0),
    .wdata (state_q == ST_CLEAR ? 32'h0 : wrep),
    .rdata (ram_rdata)
  );
  assign req_ready  = state_q == ST_IDLE;
  assign resp_valid = state_q == ST_RESP;
  assign clr_busy   = state_q == ST_CLEAR;
  // Response fields are live during RESP and otherwise replay the last response.
  assign resp_rdata = resp_valid ? fmt : hrdata_q;
  assign resp_err   = resp_valid ? err_q : herr_q;
  assign resp_pc    = resp_valid ? pc_q : hpc_q;
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    op_d       = op_q;
    lo_d       = lo_q;
    idx_d      = idx_q;
    err_d      = err_q;
    pc_d       = pc_q;
    wdata_d    = wdata_q;
    hrdata_d   = resp_rdata;
    herr_d     = resp_err;
    hpc_d      = resp_pc;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        state_d   = &clr_cnt_q ? ST_IDLE : ST_CLEAR;
      end
      ST_IDLE: if (req_valid) begin
        we_d       = req_we;
        op_d       = req_memop;
        lo_d       = off[1:0];
        idx_d      = off[ADDR_W+1:2];
        err_d      = req_err;
        pc_d       = req_pc;
        wdata_d    = req_wdata;
        wait_cnt_d = 4'h0;
        state_d    = req_err != ERR_OK ? ST_RESP : WAIT_CYC == 0 ? ST_ACCESS : ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        state_d    = wait_cnt_q == 4'(WAIT_CYC - 1) ? ST_ACCESS : ST_WAIT;
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_CLEAR;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      op_q       <= '0;
      lo_q       <= '0;
      idx_q      <= '0;
      err_q      <= '0;
      pc_q       <= '0;
      wdata_q    <= '0;
      hrdata_q   <= '0;
      herr_q     <= '0;
      hpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      op_q       <= op_d;
      lo_q       <= lo_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      pc_q       <= pc_d;
      wdata_q    <= wdata_d;
      hrdata_q   <= hrdata_d;
      herr_q     <= herr_d;
      hpc_q      <= hpc_d;
    end
  end
endmodule
